sf_capture: RTL and testbench
=============================

# sf_capture

Snapshot capture buffer for the `sf` smoothing filter. It records a burst of DEPTH consecutive (filter input, filter output) sample pairs into on-chip storage, then plays them back over a valid/ready read port. It taps the `sf` `data_in`/`data_out` nets alongside the filter and is the hardware counterpart of the simulation sample logger.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `DEPTH`, 16: pairs per capture burst; power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): pointer width, derived.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  start-capture pulse; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state; takes priority over every other input.
- `smp_in`  in  DATA_W  filter input tap (`sf.data_in`).
- `smp_out`  in  DATA_W  filter output tap (`sf.data_out`).
- `rd_valid`  out  1  a captured pair is presented on the read port.
- `rd_ready`  in  1  consumer accepts the pair this cycle.
- `rd_in`  out  DATA_W  captured `smp_in` value.
- `rd_out`  out  DATA_W  captured `smp_out` value.
- `rd_last`  out  1  presented pair is index DEPTH-1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- State machine IDLE -> CAPTURE -> DRAIN -> IDLE.
- Reset:
  - state is IDLE; `wr_ptr` and `rd_ptr` are 0.
  - `rd_valid`, `rd_last`, `busy` and `done` are 0.
  - `rd_in` and `rd_out` are 0; the storage contents are don't-care.
- IDLE:
  - `arm`=1 at an edge moves to CAPTURE with `wr_ptr`=0.
  - Nothing is written in the arm cycle itself.
- CAPTURE:
  - At every edge, {`smp_in`, `smp_out`} is written to `mem[wr_ptr]` and `wr_ptr` increments.
  - The write at `wr_ptr`=DEPTH-1 moves the state to DRAIN with `rd_ptr`=0.
  - There is no stall: exactly DEPTH consecutive samples are taken.
- DRAIN:
  - `rd_valid`=1. `rd_in`/`rd_out` are driven from `mem[rd_ptr]`.
  - `rd_last` = (`rd_ptr`==DEPTH-1).
  - On a handshake (`rd_valid` && `rd_ready`), `rd_ptr` increments.
  - The handshake with `rd_last`=1 moves the state to IDLE and asserts `done` for the following cycle.
- Handshake rules:
  - `rd_valid` never depends on `rd_ready`.
  - While `rd_valid` && !`rd_ready`, the outputs hold stable.
  - Pairs come out in capture order, each exactly once.
- `arm` in CAPTURE or DRAIN is ignored. There is no restart and no queued arm.
- `abort`:
  - Moves to IDLE next edge and clears both pointers.
  - `done` is not pulsed and `rd_valid` drops the next cycle.
  - `arm` and `abort` together: abort wins and the state stays IDLE.
- Arithmetic: values are stored and returned bit-exact, with no scaling or saturation. The pointers wrap naturally at DEPTH; the wrap coincides with the state change.
- `rd_in`/`rd_out` outside DRAIN are don't-care; the bench checks them only when `rd_valid`=1.

## Timing
- Let `arm` be sampled at edge t.
  - The pair present at edge t+1 is index 0.
  - The pair present at edge t+DEPTH is index DEPTH-1.
- `rd_valid` rises after edge t+DEPTH. First pair latency from `arm` is DEPTH+1 cycles.
- With `rd_ready` held high, the drain takes DEPTH cycles.
  - `done` is high during cycle t+2·DEPTH+1.
  - `busy` falls in that same cycle.
- Read data is a combinational read of registered storage at `rd_ptr`. It has no extra latency.
- `abort` at edge a gives `busy`=0 and `rd_valid`=0 from a+1 onward.

## Structure
- Package `sf_pkg`:
  - `DATA_W` default.
  - `cap_state_t` enum {IDLE, CAPTURE, DRAIN}.
  - Packed pair typedef {in, out}.
- Sub-module `sf_cap_mem`: DEPTH × 2·DATA_W storage with a synchronous write port and an asynchronous read port. Written as a plain reg array so it maps to distributed RAM.
- The top level holds the FSM, both pointers, and the `done` register.

## Test plan
All scenarios use DEPTH=4.
- Reset: assert `rst` 2 cycles mid-drain -> next cycle all outputs 0, state IDLE; `arm` then works normally.
- Basic burst:
  - `arm`, then `smp_in` = 100, 200, 150, 250 with `smp_out` = 10, 20, 30, 40, `rd_ready`=1.
  - Expect `rd_valid` 5 cycles after `arm`, pairs (100,10) (200,20) (150,30) (250,40) in order.
  - Expect `rd_last` only on (250,40), then a single `done` pulse.
- Backpressure: same burst with `rd_ready`=0 for 3 cycles at the first pair -> (100,10) held stable with `rd_valid`=1, then the remaining pairs are unchanged.
- Ignored arm: pulse `arm` during CAPTURE and during DRAIN -> capture data and drain order are unaffected, and exactly one `done`.
- Abort:
  - `abort` after 2 captured samples -> `busy`=0 the next cycle, no `rd_valid`, no `done`.
  - A new `arm` captures from index 0 (fresh values 180, 120, 200, 220).
- Extremes: `smp_in`/`smp_out` = -32768 / 32767 / -1 / 0 -> read back bit-exact.

Source files
------------

// File: rtl/sf_pkg.sv
// sf_pkg: shared types and defaults for the sf smoothing filter capture path
package sf_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
    typedef struct packed {
        logic signed [DATA_W-1:0] in_val;
        logic signed [DATA_W-1:0] out_val;
    } pair_t;
endpackage

// File: rtl/sf_cap_mem.sv
// sf_cap_mem: capture storage with a synchronous write port and an asynchronous read port
module sf_cap_mem #(
    parameter int W      = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [W-1:0]      wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [W-1:0]      rd
);
    logic [W-1:0] mem [DEPTH];
    // unreset array so it maps onto distributed RAM
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    assign rd = mem[ra];
endmodule

// File: rtl/sf_capture.sv
// sf_capture: records a burst of DEPTH (input, output) sample pairs and replays them over valid/ready
import sf_pkg::*;
module sf_capture #(
    parameter int DATA_W = sf_pkg::DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] smp_in,
    input  logic [DATA_W-1:0] smp_out,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_in,
    output logic [DATA_W-1:0] rd_out,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    cap_state_t state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_n, rd_ptr, rd_n;
    logic done_n, we;
    logic [2*DATA_W-1:0] rd_pair;
    sf_cap_mem #(.W(2*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk (clk),
        .we  (we),
        .wa  (wr_ptr),
        .wd  ({smp_in, smp_out}),
        .ra  (rd_ptr),
        .rd  (rd_pair)
    );
    // state, pointers and the done pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            done   <= done_n;
        end
    end
    // next state: abort overrides everything; pointer wrap coincides with the state change
    always_comb begin
        state_n = state;
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        done_n  = 1'b0;
        we      = 1'b0;
        if (abort) begin
            state_n = IDLE;
            wr_n    = '0;
            rd_n    = '0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    state_n = CAPTURE;
                    wr_n    = '0;
                end
                CAPTURE: begin
                    we   = 1'b1;
                    wr_n = wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        state_n = DRAIN;
                        rd_n    = '0;
                    end
                end
                DRAIN: if (rd_ready) begin
                    rd_n = rd_ptr + 1'b1;
                    if (rd_ptr == LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign rd_valid = (state == DRAIN);
    assign rd_last  = rd_valid && (rd_ptr == LAST);
    assign busy     = (state != IDLE);
    assign rd_in    = rd_valid ? rd_pair[2*DATA_W-1:DATA_W] : '0;
    assign rd_out   = rd_valid ? rd_pair[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_sf_capture.sv
// tb_sf_capture: directed self-checking bench for sf_capture at DEPTH=4
module tb_sf_capture;
    logic clk = 0, rst = 1, arm = 0, abort = 0, rd_ready = 0;
    logic [15:0] smp_in = 0, smp_out = 0;
    logic rd_valid, rd_last, busy, done;
    logic [15:0] rd_in, rd_out;
    logic [15:0] ei [4];
    logic [15:0] eo [4];
    int passed = 0, total = 0;

    sf_capture #(.DATA_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .smp_in(smp_in), .smp_out(smp_out),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_in(rd_in), .rd_out(rd_out), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_burst(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        ei[0] = a0; ei[1] = a1; ei[2] = a2; ei[3] = a3;
        eo[0] = b0; eo[1] = b1; eo[2] = b2; eo[3] = b3;
    endtask

    task automatic capture();
        arm = 1;
        tick();
        arm = 0;
        for (int i = 0; i < 4; i++) begin
            smp_in = ei[i];
            smp_out = eo[i];
            tick();
        end
        smp_in = 16'h5555;
        smp_out = 16'haaaa;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
        total++; if ({rd_valid, rd_last, busy, done, rd_in, rd_out} !== 36'd0) $display("FAIL reset_init got %h want 0", {rd_valid, rd_last, busy, done, rd_in, rd_out}); else passed++;
        set_burst(1, 2, 3, 4, 5, 6, 7, 8);
        rd_ready = 1;
        capture();
        tick();
        total++; if (rd_valid !== 1'b1 || rd_in !== 16'd2) $display("FAIL reset_predrain got v=%b in=%0d want v=1 in=2", rd_valid, rd_in); else passed++;
        rst = 1;
        tick(); tick();
        rst = 0;
        total++; if ({rd_valid, rd_last, busy, done, rd_in, rd_out} !== 36'd0) $display("FAIL reset_middrain got %h want 0", {rd_valid, rd_last, busy, done, rd_in, rd_out}); else passed++;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done); else passed++;
    endtask

    task automatic test_basic();
        set_burst(100, 200, 150, 250, 10, 20, 30, 40);
        rd_ready = 1;
        arm = 1;
        tick();
        arm = 0;
        total++; if (busy !== 1'b1 || rd_valid !== 1'b0) $display("FAIL basic_armed got busy=%b v=%b want 1 0", busy, rd_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b0) $display("FAIL basic_novalid%0d got %b want 0", i, rd_valid); else passed++;
            smp_in = ei[i]; smp_out = eo[i];
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_in !== ei[i] || rd_out !== eo[i] || rd_last !== (i == 3) || done !== 1'b0)
                $display("FAIL basic_pair%0d got v=%b (%0d,%0d) last=%b done=%b want v=1 (%0d,%0d) last=%b done=0", i, rd_valid, rd_in, rd_out, rd_last, done, ei[i], eo[i], i == 3);
            else passed++;
            tick();
        end
        total++; if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL basic_done got done=%b busy=%b v=%b want 1 0 0", done, busy, rd_valid); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_backpressure();
        set_burst(100, 200, 150, 250, 10, 20, 30, 40);
        rd_ready = 0;
        capture();
        for (int k = 0; k < 3; k++) begin
            total++; if (rd_valid !== 1'b1 || rd_in !== 16'd100 || rd_out !== 16'd10 || rd_last !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b (%0d,%0d) last=%b want v=1 (100,10) last=0", k, rd_valid, rd_in, rd_out, rd_last);
            else passed++;
            tick();
        end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_in !== ei[i] || rd_out !== eo[i] || rd_last !== (i == 3))
                $display("FAIL bp_pair%0d got v=%b (%0d,%0d) last=%b want v=1 (%0d,%0d) last=%b", i, rd_valid, rd_in, rd_out, rd_last, ei[i], eo[i], i == 3);
            else passed++;
            tick();
        end
        total++; if (done !== 1'b1) $display("FAIL bp_done got %b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_ignored_arm();
        int dones = 0;
        set_burst(11, 22, 33, 44, 55, 66, 77, 88);
        rd_ready = 1;
        arm = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            arm = (i == 1);
            smp_in = ei[i]; smp_out = eo[i];
            tick();
        end
        arm = 0;
        for (int i = 0; i < 4; i++) begin
            arm = (i == 1);
            total++; if (rd_valid !== 1'b1 || rd_in !== ei[i] || rd_out !== eo[i])
                $display("FAIL ign_pair%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, rd_valid, rd_in, rd_out, ei[i], eo[i]);
            else passed++;
            tick();
        end
        arm = 0;
        for (int k = 0; k < 8; k++) begin
            dones += int'(done);
            tick();
        end
        total++; if (dones !== 1) $display("FAIL ign_done_count got %0d want 1", dones); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ign_idle got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_abort();
        int bad = 0;
        rd_ready = 1;
        arm = 1;
        tick();
        arm = 0;
        smp_in = 1; smp_out = 2; tick();
        smp_in = 3; smp_out = 4; tick();
        abort = 1;
        tick();
        abort = 0;
        total++; if (busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL abort_idle got busy=%b v=%b want 0 0", busy, rd_valid); else passed++;
        for (int k = 0; k < 6; k++) begin
            bad += int'(done | rd_valid | busy);
            tick();
        end
        total++; if (bad !== 0) $display("FAIL abort_quiet got %0d active cycles want 0", bad); else passed++;
        arm = 1; abort = 1;
        tick();
        arm = 0; abort = 0;
        total++; if (busy !== 1'b0) $display("FAIL abort_wins got busy=%b want 0", busy); else passed++;
        set_burst(180, 120, 200, 220, 1, 2, 3, 4);
        capture();
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_in !== ei[i] || rd_out !== eo[i] || rd_last !== (i == 3))
                $display("FAIL abort_rearm%0d got v=%b (%0d,%0d) last=%b want v=1 (%0d,%0d) last=%b", i, rd_valid, rd_in, rd_out, rd_last, ei[i], eo[i], i == 3);
            else passed++;
            tick();
        end
        total++; if (done !== 1'b1) $display("FAIL abort_rearm_done got %b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_extremes();
        set_burst(16'h8000, 16'h7fff, 16'hffff, 16'h0000, 16'h7fff, 16'h8000, 16'h0000, 16'hffff);
        rd_ready = 1;
        capture();
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_in !== ei[i] || rd_out !== eo[i])
                $display("FAIL ext_pair%0d got v=%b (%h,%h) want v=1 (%h,%h)", i, rd_valid, rd_in, rd_out, ei[i], eo[i]);
            else passed++;
            tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_arm();
        test_abort();
        test_extremes();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
